// File: rtl/button_event_ctrl_if.sv
// Switch-level input and classified-event outputs of the press classifier.
// The master side drives the debounced switch; the slave side is the classifier.
interface button_event_ctrl_if;
   logic i_Stable_Switch;
   logic o_Short;
   logic o_Long;
   logic o_Double;
   logic o_LED_1;
   logic o_LED_2;
   logic o_LED_3;

   modport master (
      output i_Stable_Switch,
      input  o_Short, o_Long, o_Double, o_LED_1, o_LED_2, o_LED_3
   );

   modport slave (
      input  i_Stable_Switch,
      output o_Short, o_Long, o_Double, o_LED_1, o_LED_2, o_LED_3
   );
endinterface

// File: rtl/button_event_ctrl.sv
// Classifies each debounced press sequence as short, long or double using one
// shared duration counter, and drives three LEDs from the resulting events.
module button_event_ctrl #(
   parameter int CLKS_LONG   = 12500000,
   parameter int CLKS_DOUBLE = 6250000,
   parameter int CNT_W       = 24
) (
   input logic i_Clk,
   input logic i_Reset,
   button_event_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRESS1    = 3'd1,
      WAIT2     = 3'd2,
      PRESS2    = 3'd3,
      LONG_HOLD = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(CLKS_LONG - 1);
   localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(CLKS_DOUBLE - 1);

   state_t           r_State;
   logic [CNT_W-1:0] r_Cnt;
   logic             r_Sw;
   logic             r_Short, r_Long, r_Double;
   logic             r_LED_1, r_LED_2, r_LED_3;
   logic             w_In, w_Rise;

   assign w_In   = bus.i_Stable_Switch;
   assign w_Rise = w_In & ~r_Sw;

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_State  <= IDLE;
         r_Cnt    <= '0;
         // A switch held through reset must be released before it can press.
         r_Sw     <= 1'b1;
         r_Short  <= 1'b0;
         r_Long   <= 1'b0;
         r_Double <= 1'b0;
         r_LED_1  <= 1'b0;
         r_LED_2  <= 1'b0;
         r_LED_3  <= 1'b0;
      end else begin
         r_Sw     <= w_In;
         // NOTE: pulse defaults precede the case so every event lasts one cycle.
         r_Short  <= 1'b0;
         r_Long   <= 1'b0;
         r_Double <= 1'b0;
         case (r_State)
            IDLE: begin
               if (w_Rise) begin
                  r_State <= PRESS1;
                  r_Cnt   <= '0;
               end
            end
            PRESS1: begin
               if (!w_In) begin
                  r_State <= WAIT2;
                  r_Cnt   <= '0;
               end else if (r_Cnt == LONG_LAST) begin
                  r_State <= LONG_HOLD;
                  r_Cnt   <= '0;
                  r_Long  <= 1'b1;
                  r_LED_3 <= 1'b1;
               end else begin
                  r_Cnt <= r_Cnt + 1'b1;
               end
            end
            WAIT2: begin
               // A second press on the timeout cycle still counts as double.
               if (w_Rise) begin
                  r_State <= PRESS2;
                  r_Cnt   <= '0;
               end else if (r_Cnt == DOUBLE_LAST) begin
                  r_State <= IDLE;
                  r_Cnt   <= '0;
                  r_Short <= 1'b1;
                  r_LED_1 <= ~r_LED_1;
               end else begin
                  r_Cnt <= r_Cnt + 1'b1;
               end
            end
            PRESS2: begin
               if (!w_In) begin
                  r_State  <= IDLE;
                  r_Cnt    <= '0;
                  r_Double <= 1'b1;
                  r_LED_2  <= ~r_LED_2;
               end
            end
            LONG_HOLD: begin
               if (!w_In) begin
                  r_State <= IDLE;
                  r_Cnt   <= '0;
                  r_LED_3 <= 1'b0;
               end
            end
            default: begin
               r_State <= IDLE;
               r_Cnt   <= '0;
               r_LED_3 <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_Short  = r_Short;
   assign bus.o_Long   = r_Long;
   assign bus.o_Double = r_Double;
   assign bus.o_LED_1  = r_LED_1;
   assign bus.o_LED_2  = r_LED_2;
   assign bus.o_LED_3  = r_LED_3;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: directed and random switch patterns replayed
// against a run-length press classifier, compared edge by edge.
module tb_button_event_ctrl;

   localparam int L = 8;
   localparam int D = 5;
   localparam int N = 1024;

   logic i_Clk;
   logic i_Reset;
   button_event_ctrl_if bus ();

   button_event_ctrl #(.CLKS_LONG(L), .CLKS_DOUBLE(D), .CNT_W(4)) dut (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .bus     (bus.slave)
   );

   initial begin
      i_Clk = 1'b0;
      forever #5 i_Clk = ~i_Clk;
   end

   // Stimulus per clock edge, expected and observed {short,long,double,led1,led2,led3}.
   bit         st_in [N];
   bit         st_rst[N];
   int         n;
   bit         ex_s[N], ex_l[N], ex_d[N], ex_3[N];
   logic [5:0] exp_v[N];
   logic [5:0] obs[N];
   int         n_cmp = 0;
   int         n_bad = 0;

   task automatic push(input bit lvl, input int cnt, input bit rs = 1'b0);
      for (int i = 0; i < cnt; i++) begin
         if (n < N) begin
            st_in[n]  = lvl;
            st_rst[n] = rs;
            n++;
         end
      end
   endtask

   task automatic begin_scn();
      n = 0;
      push(1'b0, 2, 1'b1);
   endtask

   function automatic int run_hi(input int s);
      int k = 0;
      while (s + k < n && st_in[s+k]) k++;
      return k;
   endfunction

   function automatic int first_rst(input int a, input int b);
      for (int i = a; i <= b && i < n; i++) if (st_rst[i]) return i;
      return -1;
   endfunction

   // Walks press sequences as run lengths: hold >= L+1 samples is long, otherwise
   // a follow-up press starting within D samples of the release is double.
   task automatic model();
      int  e, t, h, f, r2, evt, rr, lend;
      bit  prev, l1, l2;
      for (int i = 0; i < N; i++) begin
         ex_s[i] = 0; ex_l[i] = 0; ex_d[i] = 0; ex_3[i] = 0;
      end
      e = 0;
      while (e < n) begin
         prev = (e == 0 || st_rst[e-1]) ? 1'b1 : st_in[e-1];
         if (st_rst[e] || !st_in[e] || prev) begin
            e++;
            continue;
         end
         t = e;
         h = run_hi(t);
         if (h >= L + 1) begin
            evt = t + L;
            rr  = first_rst(t, t + h);
            if (rr != -1 && rr <= evt) begin
               e = rr;
               continue;
            end
            ex_l[evt] = 1;
            lend = (rr != -1) ? rr : t + h;
            for (int i = evt; i < lend && i < n; i++) ex_3[i] = 1;
            e = lend;
            continue;
         end
         f = t + h;
         if (f >= n) break;
         r2 = -1;
         for (int i = f + 1; i <= f + D && i < n; i++) begin
            if (st_in[i]) begin
               r2 = i;
               break;
            end
         end
         evt = (r2 == -1) ? f + D : r2 + run_hi(r2);
         rr  = first_rst(t, evt);
         if (rr != -1) begin
            e = rr;
            continue;
         end
         if (evt >= n) break;
         if (r2 == -1) ex_s[evt] = 1;
         else          ex_d[evt] = 1;
         e = evt;
      end
      l1 = 0;
      l2 = 0;
      for (int i = 0; i < n; i++) begin
         if (st_rst[i]) begin
            l1 = 0;
            l2 = 0;
         end else begin
            l1 = l1 ^ ex_s[i];
            l2 = l2 ^ ex_d[i];
         end
         exp_v[i] = {ex_s[i], ex_l[i], ex_d[i], l1, l2, ex_3[i]};
      end
   endtask

   // Drives sample i before edge i and records the outputs registered at edge i.
   task automatic play();
      for (int i = 0; i <= n; i++) begin
         @(negedge i_Clk);
         if (i > 0)
            obs[i-1] = {bus.o_Short, bus.o_Long, bus.o_Double,
                        bus.o_LED_1, bus.o_LED_2, bus.o_LED_3};
         if (i < n) begin
            bus.i_Stable_Switch = st_in[i];
            i_Reset             = st_rst[i];
         end
      end
   endtask

   function automatic int count_bit(input int b);
      int c = 0;
      for (int i = 0; i < n; i++) if (obs[i][b]) c++;
      return c;
   endfunction

   task automatic test_reset();
      logic [5:0] any;
      n = 0;
      push(1'b1, 20, 1'b1);
      push(1'b1, 5);
      push(1'b0, 20);
      model();
      play();
      for (int i = 0; i < n; i++) begin
         n_cmp++;
         if (obs[i] !== exp_v[i]) begin
            n_bad++;
            $display("FAIL reset e%0d: observed %b expected %b", i, obs[i], exp_v[i]);
         end
      end
      any = '0;
      for (int i = 0; i < n; i++) any = any | obs[i];
      n_cmp++;
      if (any !== 6'b0) begin
         n_bad++;
         $display("FAIL reset_quiet: observed %b expected 000000", any);
      end
   endtask

   task automatic test_short();
      int t, f;
      begin_scn();
      push(1'b0, 3);
      t = n;
      push(1'b1, 3);
      f = n;
      push(1'b0, 15);
      model();
      play();
      for (int i = 0; i < n; i++) begin
         n_cmp++;
         if (obs[i] !== exp_v[i]) begin
            n_bad++;
            $display("FAIL short e%0d: observed %b expected %b", i, obs[i], exp_v[i]);
         end
      end
      n_cmp++;
      if (obs[f+D][5] !== 1'b1 || count_bit(5) != 1 || f != t + 3) begin
         n_bad++;
         $display("FAIL short_timing: observed pulse %b count %0d expected 1 at edge %0d",
                  obs[f+D][5], count_bit(5), f + D);
      end
      n_cmp++;
      if (obs[n-1][2] !== 1'b1 || count_bit(4) != 0 || count_bit(3) != 0) begin
         n_bad++;
         $display("FAIL short_led1: observed led1 %b long %0d double %0d expected 1/0/0",
                  obs[n-1][2], count_bit(4), count_bit(3));
      end
   endtask

   task automatic test_long_threshold();
      int t, rel, t2, f2;
      begin_scn();
      push(1'b0, 3);
      t = n;
      push(1'b1, 9);
      rel = n;
      push(1'b0, 10);
      t2 = n;
      push(1'b1, 8);
      f2 = n;
      push(1'b0, 12);
      model();
      play();
      for (int i = 0; i < n; i++) begin
         n_cmp++;
         if (obs[i] !== exp_v[i]) begin
            n_bad++;
            $display("FAIL long e%0d: observed %b expected %b", i, obs[i], exp_v[i]);
         end
      end
      n_cmp++;
      if (obs[t+L][4] !== 1'b1 || obs[t+L][0] !== 1'b1 || obs[rel][0] !== 1'b0) begin
         n_bad++;
         $display("FAIL long_edge: observed long %b led3 %b/%b expected 1 1/0",
                  obs[t+L][4], obs[t+L][0], obs[rel][0]);
      end
      n_cmp++;
      if (obs[f2+D][5] !== 1'b1 || count_bit(4) != 1 || f2 != t2 + L) begin
         n_bad++;
         $display("FAIL long_below: observed short %b long count %0d expected 1 and 1",
                  obs[f2+D][5], count_bit(4));
      end
   endtask

   task automatic test_double();
      int rel1, rel2;
      begin_scn();
      push(1'b0, 3);
      push(1'b1, 2);
      push(1'b0, 3);
      push(1'b1, 2);
      rel1 = n;
      push(1'b0, 10);
      push(1'b1, 2);
      push(1'b0, 5);
      push(1'b1, 2);
      rel2 = n;
      push(1'b0, 10);
      model();
      play();
      for (int i = 0; i < n; i++) begin
         n_cmp++;
         if (obs[i] !== exp_v[i]) begin
            n_bad++;
            $display("FAIL double e%0d: observed %b expected %b", i, obs[i], exp_v[i]);
         end
      end
      n_cmp++;
      if (obs[rel1][3] !== 1'b1 || obs[rel1][1] !== 1'b1) begin
         n_bad++;
         $display("FAIL double_gap3: observed double %b led2 %b expected 1 1",
                  obs[rel1][3], obs[rel1][1]);
      end
      n_cmp++;
      if (obs[rel2][3] !== 1'b1 || count_bit(5) != 0 || obs[n-1][1] !== 1'b0) begin
         n_bad++;
         $display("FAIL double_gap5: observed double %b shorts %0d led2 %b expected 1 0 0",
                  obs[rel2][3], count_bit(5), obs[n-1][1]);
      end
   endtask

   task automatic test_reset_mid();
      int f, quiet_end;
      begin_scn();
      push(1'b0, 2);
      push(1'b1, 3);  push(1'b1, 1, 1'b1);  push(1'b1, 2);  push(1'b0, 10);
      push(1'b1, 2);  push(1'b0, 2);  push(1'b0, 1, 1'b1);  push(1'b0, 10);
      push(1'b1, 2);  push(1'b0, 2);  push(1'b1, 2);  push(1'b1, 1, 1'b1);
      push(1'b0, 10);
      push(1'b1, 12); push(1'b1, 1, 1'b1);  push(1'b1, 3);  push(1'b0, 10);
      quiet_end = n;
      push(1'b1, 2);
      f = n;
      push(1'b0, 12);
      model();
      play();
      for (int i = 0; i < n; i++) begin
         n_cmp++;
         if (obs[i] !== exp_v[i]) begin
            n_bad++;
            $display("FAIL reset_mid e%0d: observed %b expected %b", i, obs[i], exp_v[i]);
         end
      end
      for (int i = 0; i < quiet_end; i++) begin
         if (obs[i][5:3] !== 3'b0 && obs[i][2:1] !== 2'b0) begin
            n_bad++;
            $display("FAIL reset_mid_quiet e%0d: observed %b expected 000000", i, obs[i]);
         end
      end
      n_cmp++;
      if (obs[f+D][5] !== 1'b1 || count_bit(5) != 1 || count_bit(3) != 0) begin
         n_bad++;
         $display("FAIL reset_mid_recover: observed short %b count %0d expected 1 and 1",
                  obs[f+D][5], count_bit(5));
      end
   endtask

   task automatic test_back_to_back();
      begin_scn();
      push(1'b0, 2);
      for (int k = 0; k < 3; k++) begin
         push(1'b1, 2);
         push(1'b0, 10);
      end
      model();
      play();
      for (int i = 0; i < n; i++) begin
         n_cmp++;
         if (obs[i] !== exp_v[i]) begin
            n_bad++;
            $display("FAIL b2b e%0d: observed %b expected %b", i, obs[i], exp_v[i]);
         end
      end
      n_cmp++;
      if (count_bit(5) != 3 || obs[n-1][2] !== 1'b1) begin
         n_bad++;
         $display("FAIL b2b_count: observed shorts %0d led1 %b expected 3 1",
                  count_bit(5), obs[n-1][2]);
      end
   endtask

   task automatic test_random();
      begin_scn();
      push(1'b0, 2);
      for (int k = 0; k < 40; k++) begin
         push(1'b1, $urandom_range(1, 12));
         push(1'b0, $urandom_range(1, 9));
         if ($urandom_range(0, 7) == 0) push(1'($urandom_range(0, 1)), 1, 1'b1);
      end
      push(1'b0, 12);
      model();
      play();
      for (int i = 0; i < n; i++) begin
         n_cmp++;
         if (obs[i] !== exp_v[i]) begin
            n_bad++;
            $display("FAIL random e%0d: observed %b expected %b", i, obs[i], exp_v[i]);
         end
      end
   endtask

   initial begin
      i_Reset             = 1'b1;
      bus.i_Stable_Switch = 1'b0;
      test_reset();
      test_short();
      test_long_threshold();
      test_double();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
